// File: rtl/store_data_narrow.sv
// ---------------------------------------------------------------------------
// store_data_narrow
//
// Store-path formatter for the pipelined RV32I core. It takes the rs2 value,
// the store funct3 and the effective byte address from EX/MEM, narrows the
// value to a byte, halfword or word, and replicates it across the lanes it
// will be written to. It also produces byte strobes and a word address for
// data memory. There is one registered stage with valid/ready on both sides.
// A two-entry store (output register + skid register) lets the core absorb
// memory back-pressure without dropping a store.
//
// Optional feature macro: STORE_MISALIGN_TRAP_EN
//   defined   : a misaligned SH/SW gets strb=0000 and err=1, so memory is left
//               untouched and the trap unit picks up err.
//   undefined : a misaligned SH/SW is force-aligned (SH ignores addr[0], SW
//               ignores addr[1:0]) and err=0.
//   An illegal funct3 sets err in both builds.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   store request valid
//   in_ready   formatter can take a request this cycle (registered, !skid_full)
//   in_data    rs2 value
//   in_funct3  store funct3 (000 SB, 001 SH, 010 SW)
//   in_addr    effective byte address
//   out_valid  formatted store valid
//   out_ready  memory accepts the store
//   out_data   lane-replicated write data
//   out_strb   byte-enable strobes
//   out_waddr  word address, in_addr[ADDR_W-1:2]
//   out_err    illegal funct3 or (trap build) misaligned access
// ---------------------------------------------------------------------------
module store_data_narrow #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_data,
  input  logic [2:0]          in_funct3,
  input  logic [ADDR_W-1:0]   in_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_data,
  output logic [XLEN/8-1:0]   out_strb,
  output logic [ADDR_W-3:0]   out_waddr,
  output logic                out_err
);

  localparam int STRB_W = XLEN / 8;

  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [STRB_W-1:0] strb;
    logic [ADDR_W-3:0] waddr;
    logic              err;
  } entry_t;

  entry_t fmt;
  entry_t out_q;
  entry_t skid_q;
  logic   out_valid_q;
  logic   skid_full_q;
  logic   in_xfer;
  logic   out_free;

  // Format the incoming request entirely on the input side. The finished
  // entry is what gets stored, so nothing is recomputed downstream.
  always_comb begin
    fmt       = '0;
    fmt.waddr = in_addr[ADDR_W-1:2];
    fmt.data  = in_data;
    fmt.strb  = '0;
    fmt.err   = 1'b0;
    case (in_funct3)
      3'b000: begin
        fmt.data = {4{in_data[7:0]}};
        fmt.strb = 4'b0001 << in_addr[1:0];
      end
      3'b001: begin
        // addr[0] is simply not looked at, which force-aligns a misaligned SH.
        fmt.data = {2{in_data[15:0]}};
        fmt.strb = in_addr[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_MISALIGN_TRAP_EN
        if (in_addr[0]) begin
          fmt.strb = '0;
          fmt.err  = 1'b1;
        end
`endif
      end
      3'b010: begin
        fmt.strb = 4'b1111;
`ifdef STORE_MISALIGN_TRAP_EN
        if (in_addr[1:0] != 2'b00) begin
          fmt.strb = '0;
          fmt.err  = 1'b1;
        end
`endif
      end
      default: begin
        // Illegal funct3 still travels through so the trap unit sees it.
        fmt.strb = '0;
        fmt.err  = 1'b1;
      end
    endcase
  end

  assign in_ready = !skid_full_q;
  assign in_xfer  = in_valid && !skid_full_q;
  // The output register can be loaded when it is empty or is being drained.
  assign out_free = !out_valid_q || out_ready;

  // Two-entry storage. The skid register only fills while the output is
  // stalled, and it always refills the output before any new request does.
  // That keeps stores in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_full_q) begin
          out_q       <= skid_q;
          out_valid_q <= 1'b1;
          skid_full_q <= 1'b0;
        end else if (in_xfer) begin
          out_q       <= fmt;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_q      <= fmt;
        skid_full_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_strb  = out_q.strb;
  assign out_waddr = out_q.waddr;
  assign out_err   = out_q.err;

endmodule

// File: tb/tb_store_data_narrow.sv
// ---------------------------------------------------------------------------
// tb_store_data_narrow
//
// Bench for store_data_narrow. It runs directed vectors from a table, then
// hand-written back-pressure and reset sequences, and then random traffic
// against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_store_data_narrow;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic [29:0] out_waddr;
  logic        out_err;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [2:0]  funct3;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    logic [29:0] exp_waddr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [29:0] waddr;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t model_q[$];

  store_data_narrow #(.XLEN(32), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_funct3 (in_funct3),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_strb  (out_strb),
    .out_waddr (out_waddr),
    .out_err   (out_err)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference formatting, computed from the store rules with plain arithmetic.
  function automatic exp_t ref_format(logic [2:0] f3, logic [31:0] d, logic [31:0] a);
    exp_t e;
    int   lane;
    lane    = int'(a[1:0]);
    e.waddr = a[31:2];
    e.data  = d;
    e.strb  = 4'd0;
    e.err   = 1'b1;
    if (f3 == 3'd0) begin
      e.data = {24'd0, d[7:0]} * 32'h0101_0101;
      e.strb = 4'(1 << lane);
      e.err  = 1'b0;
    end else if (f3 == 3'd1) begin
      e.data = {16'd0, d[15:0]} * 32'h0001_0001;
      e.strb = (lane >= 2) ? 4'd12 : 4'd3;
      e.err  = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      if (lane % 2 != 0) begin
        e.strb = 4'd0;
        e.err  = 1'b1;
      end
`endif
    end else if (f3 == 3'd2) begin
      e.strb = 4'd15;
      e.err  = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      if (lane != 0) begin
        e.strb = 4'd0;
        e.err  = 1'b1;
      end
`endif
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic v, input logic [2:0] f3,
                               input logic [31:0] d, input logic [31:0] a);
    in_valid  = v;
    in_funct3 = f3;
    in_data   = d;
    in_addr   = a;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Directed vectors. The misaligned rows depend on which build is compiled.
  task automatic fill_vectors();
    vecs.push_back('{3'b000, 32'h1234_56A7, 32'h0000_1003, 32'hA7A7_A7A7, 4'b1000, 30'h400, 1'b0});
    vecs.push_back('{3'b001, 32'hDEAD_BEEF, 32'h0000_0002, 32'hBEEF_BEEF, 4'b1100, 30'h0,   1'b0});
    vecs.push_back('{3'b010, 32'hDEAD_BEEF, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 30'h4,   1'b0});
    vecs.push_back('{3'b000, 32'h0000_005A, 32'h0000_0000, 32'h5A5A_5A5A, 4'b0001, 30'h0,   1'b0});
    vecs.push_back('{3'b011, 32'h1122_3344, 32'h0000_0008, 32'h1122_3344, 4'b0000, 30'h2,   1'b1});
    vecs.push_back('{3'b100, 32'h5566_7788, 32'h0000_0001, 32'h5566_7788, 4'b0000, 30'h0,   1'b1});
    vecs.push_back('{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'b0000, 30'h3FFF_FFFF, 1'b1});
`ifdef STORE_MISALIGN_TRAP_EN
    vecs.push_back('{3'b010, 32'hCAFE_F00D, 32'h0000_0006, 32'hCAFE_F00D, 4'b0000, 30'h1,   1'b1});
    vecs.push_back('{3'b001, 32'h0000_ABCD, 32'h0000_0001, 32'hABCD_ABCD, 4'b0000, 30'h0,   1'b1});
    vecs.push_back('{3'b001, 32'h0000_1234, 32'h0000_0003, 32'h1234_1234, 4'b0000, 30'h0,   1'b1});
`else
    vecs.push_back('{3'b010, 32'hCAFE_F00D, 32'h0000_0006, 32'hCAFE_F00D, 4'b1111, 30'h1,   1'b0});
    vecs.push_back('{3'b001, 32'h0000_ABCD, 32'h0000_0001, 32'hABCD_ABCD, 4'b0011, 30'h0,   1'b0});
    vecs.push_back('{3'b001, 32'h0000_1234, 32'h0000_0003, 32'h1234_1234, 4'b1100, 30'h0,   1'b0});
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Main sequence: reset, table, back-pressure, reset mid-flight, then random.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    out_ready    = 1'b1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    fill_vectors();
    do_reset();

    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset_strb",      32'(out_strb),  32'd0);
    checkOutput("reset_data",      out_data,       32'd0);
    checkOutput("reset_err",       32'(out_err),   32'd0);
    checkOutput("reset_waddr",     32'(out_waddr), 32'd0);

    // Table-driven formatting checks, one store per cycle with out_ready high.
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].funct3, vecs[i].data, vecs[i].addr);
      tick();
      applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_data",  i), out_data,       vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_strb",  i), 32'(out_strb),  32'(vecs[i].exp_strb));
      checkOutput($sformatf("vec%0d_waddr", i), 32'(out_waddr), 32'(vecs[i].exp_waddr));
      checkOutput($sformatf("vec%0d_err",   i), 32'(out_err),   32'(vecs[i].exp_err));
    end
    tick();
    checkOutput("table_drain_valid", 32'(out_valid), 32'd0);

    // Back-pressure: three back-to-back SBs with memory stalled.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'h0000_0011, 32'h0000_0000);
    tick();
    checkOutput("bp_a_valid",    32'(out_valid), 32'd1);
    checkOutput("bp_a_data",     out_data,       32'h1111_1111);
    checkOutput("bp_a_in_ready", 32'(in_ready),  32'd1);
    applyStimulus(1'b1, 3'b000, 32'h0000_0022, 32'h0000_0001);
    tick();
    checkOutput("bp_b_in_ready", 32'(in_ready),  32'd0);
    checkOutput("bp_b_hold",     out_data,       32'h1111_1111);
    applyStimulus(1'b1, 3'b000, 32'h0000_0033, 32'h0000_0002);
    tick();
    checkOutput("bp_c_wait",     32'(in_ready),  32'd0);
    checkOutput("bp_c_hold",     out_data,       32'h1111_1111);
    checkOutput("bp_c_hstrb",    32'(out_strb),  32'b0001);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_b_out",      out_data,       32'h2222_2222);
    checkOutput("bp_b_strb",     32'(out_strb),  32'b0010);
    checkOutput("bp_b_ready",    32'(in_ready),  32'd1);
    tick();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    checkOutput("bp_c_valid",    32'(out_valid), 32'd1);
    checkOutput("bp_c_out",      out_data,       32'h3333_3333);
    checkOutput("bp_c_strb",     32'(out_strb),  32'b0100);
    tick();
    checkOutput("bp_empty",      32'(out_valid), 32'd0);

    // Reset with both entries full: outputs must clear without a clock edge.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b010, 32'hAAAA_0001, 32'h0000_0100);
    tick();
    applyStimulus(1'b1, 3'b010, 32'hAAAA_0002, 32'h0000_0104);
    tick();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    checkOutput("rst_pre_full",  32'(in_ready),  32'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_async_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("rst_no_stale",  32'(out_valid), 32'd0);

    // Random traffic against the queue model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        v;
      logic [2:0]  f3;
      logic [31:0] d;
      logic [31:0] a;
      bit          in_x;
      bit          out_x;
      checkOutput("rnd_valid", 32'(out_valid), 32'(model_q.size() > 0));
      checkOutput("rnd_ready", 32'(in_ready),  32'(model_q.size() < 2));
      if (model_q.size() > 0) begin
        checkOutput("rnd_data",  out_data,       model_q[0].data);
        checkOutput("rnd_strb",  32'(out_strb),  32'(model_q[0].strb));
        checkOutput("rnd_waddr", 32'(out_waddr), 32'(model_q[0].waddr));
        checkOutput("rnd_err",   32'(out_err),   32'(model_q[0].err));
      end
      v  = ($urandom_range(0, 3) != 0);
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2))
                                       : 3'($urandom_range(3, 7));
      d  = $urandom;
      a  = $urandom;
      applyStimulus(v, f3, d, a);
      out_ready = ($urandom_range(0, 2) != 0);
      in_x  = v && (model_q.size() < 2);
      out_x = out_ready && (model_q.size() > 0);
      @(posedge clk);
      if (out_x) void'(model_q.pop_front());
      if (in_x)  model_q.push_back(ref_format(f3, d, a));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
